if_fetch_stage: RTL

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and issues one instruction-memory request at a time. It tolerates variable memory latency and presents the fetched instruction with its PC to IF/ID. It handles hazard-unit stalls and branch/jump redirects, including redirects that arrive while a fetch is still in flight.

---
 rtl/if_fetch_stage.sv | 82 ++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner issuing one imem request at a time, presenting fetched instructions to IF/ID
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, ibuf, ibuf_nx, target;
  logic unused_low_bits;
  assign target = {redirect_pc[31:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];
  // state, PC and hold buffer registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_REQ;
      pc <= RESET_PC;
      ibuf <= NOP_INST;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      ibuf <= ibuf_nx;
    end
  end
  // next state: redirects always win, a response during a redirect is discarded
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    ibuf_nx = ibuf;
    case (state)
      S_REQ: begin
        state_nx = S_WAIT;
        pc_nx = redirect ? target : pc;
      end
      S_WAIT: begin
        if (redirect) begin
          pc_nx = target;
          state_nx = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid && !stall) begin
          pc_nx = pc + 32'd4;
          state_nx = S_REQ;
        end else if (imem_rvalid) begin
          ibuf_nx = imem_rdata;
          state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_nx = target;
          state_nx = S_REQ;
        end else if (!stall) begin
          pc_nx = pc + 32'd4;
          state_nx = S_REQ;
        end
      end
      default: begin
        pc_nx = redirect ? target : pc;
        state_nx = imem_rvalid ? S_REQ : S_DROP;
      end
    endcase
  end
  // outputs: redirect target bypasses into the request address; bubbles carry 0 / NOP_INST
  always_comb begin
    imem_req = !Rst && state == S_REQ;
    imem_addr = Rst ? 32'd0 : (state == S_REQ && redirect) ? target : pc;
    if_valid = !Rst && !redirect && (state == S_HOLD || (state == S_WAIT && imem_rvalid));
    if_pc = if_valid ? pc : 32'd0;
    if_inst = !if_valid ? NOP_INST : (state == S_HOLD) ? ibuf : imem_rdata;
  end
endmodule
